// File: rtl/line_clear_ctl.sv
// line_clear_ctl
// Post-lock line clear sequencer for the board occupancy RAM. After each
// piece lock it walks the board bottom-to-top, drops full rows, packs the
// surviving rows downward, zero-fills the vacated top rows, then scores the
// pass and advances the cumulative line count and level.
//
// Row 0 is the top of the board, row ROWS-1 the bottom. Bit i of a row is
// column i. The RAM has one cycle of read latency: data addressed in READ is
// presented during WAIT and captured at the end of that cycle.

module line_clear_ctl #(
  parameter int ROWS            = 22,
  parameter int COLS            = 10,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            start,
  input  logic [COLS-1:0] mem_rdata,
  output logic [4:0]      mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  output logic [COLS-1:0] mem_wdata,
  output logic            busy,
  output logic            done,
  output logic [2:0]      lines,
  output logic [19:0]     points_add,
  output logic [7:0]      total_lines,
  output logic [3:0]      level
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------

  // Sequencer states, kept as plain constants so the encoding stays stable for
  // existing debug tooling that decodes the state register by value.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_FILL  = 3'd4;
  localparam logic [2:0] S_SCORE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [4:0]      LAST_ROW  = 5'(ROWS - 1);
  localparam logic [COLS-1:0] FULL_ROW  = '1;
  localparam logic [3:0]      MAX_LVL   = 4'(MAX_LEVEL);
  // The level sub-counter is 4 bits wide, which holds any LINES_PER_LEVEL up
  // to 16; the sum below is one bit wider so a pass can never wrap it.
  localparam logic [4:0]      LPL       = 5'(LINES_PER_LEVEL);
  localparam logic [2:0]      LINES_MAX = 3'd7;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [4:0]      rd;          // row being read / evaluated
  logic [4:0]      wr;          // next destination row for a surviving row
  logic [COLS-1:0] row_q;       // row captured at the end of WAIT
  logic [2:0]      lines_q;     // full rows found this pass
  logic [19:0]     points_q;
  logic [7:0]      total_q;
  logic [3:0]      level_q;
  logic [3:0]      sub_q;       // lines accumulated towards the next level

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------

  logic            row_full;
  logic [2:0]      lines_inc;
  logic [2:0]      lines_after;
  logic [10:0]     base_pts;
  logic [4:0]      level_mult;
  logic [19:0]     points_calc;
  logic [8:0]      total_sum;
  logic [4:0]      sub_sum;

  // Row classification and the line count as it stands after this EVAL.
  always_comb begin
    row_full    = (row_q == FULL_ROW);
    // Saturate rather than wrap; a legal piece never clears more than four.
    lines_inc   = (lines_q == LINES_MAX) ? LINES_MAX : lines_q + 3'd1;
    lines_after = row_full ? lines_inc : lines_q;
  end

  // Score and progression arithmetic, consumed only in SCORE.
  always_comb begin
    case (lines_q)
      3'd0:    base_pts = 11'd0;
      3'd1:    base_pts = 11'd40;
      3'd2:    base_pts = 11'd100;
      3'd3:    base_pts = 11'd300;
      default: base_pts = 11'd1200;
    endcase
    level_mult  = {1'b0, level_q} + 5'd1;
    points_calc = 20'(base_pts) * 20'(level_mult);
    total_sum   = {1'b0, total_q} + 9'(lines_q);
    sub_sum     = {1'b0, sub_q} + 5'(lines_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Sequencer transitions; a start outside IDLE is dropped, not queued.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred when a branch leaves the state unchanged.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_EVAL;
      S_EVAL: begin
        if (rd == 5'd0) state_nxt = (lines_after != 3'd0) ? S_FILL : S_SCORE;
        else            state_nxt = S_READ;
      end
      S_FILL:  if (wr == 5'd0) state_nxt = S_SCORE;
      S_SCORE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any pass and makes no further accesses.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Scan datapath: read / write pointers, captured row, line count
  // ---------------------------------------------------------------------------

  // Pointer walk. wr trails rd by the number of rows cleared so far, so the
  // rows left over for FILL are exactly lines-1 .. 0.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rd      <= LAST_ROW;
      wr      <= LAST_ROW;
      row_q   <= '0;
      lines_q <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd      <= LAST_ROW;
            wr      <= LAST_ROW;
            lines_q <= 3'd0;
          end
        end
        S_WAIT: row_q <= mem_rdata;
        S_EVAL: begin
          // A full row is dropped; a surviving row is written to wr and wr
          // moves up. wr may wrap below zero after the last row, which is
          // harmless because FILL is skipped in exactly that case.
          if (row_full) lines_q <= lines_inc;
          else          wr      <= wr - 5'd1;
          if (rd != 5'd0) rd <= rd - 5'd1;
        end
        S_FILL: if (wr != 5'd0) wr <= wr - 5'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scoring and progression
  // ---------------------------------------------------------------------------

  // Score the pass once the scan is complete, then roll lines into the level.
  always_ff @(posedge pclk) begin
    if (rst) begin
      points_q <= '0;
      total_q  <= '0;
      level_q  <= '0;
      sub_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) points_q <= '0;
        S_SCORE: begin
          points_q <= points_calc;
          total_q  <= total_sum[8] ? 8'hFF : total_sum[7:0];
          // At most one level boundary per pass, since a pass clears fewer
          // lines than a level needs.
          if (sub_sum >= LPL) begin
            sub_q   <= 4'(sub_sum - LPL);
            level_q <= (level_q >= MAX_LVL) ? MAX_LVL : level_q + 4'd1;
          end else begin
            sub_q   <= sub_sum[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // RAM strobes decode straight from the current state; READ and the write
  // states are disjoint, so re and we can never coincide.
  always_comb begin
    mem_re    = (state == S_READ);
    mem_we    = ((state == S_EVAL) && !row_full) || (state == S_FILL);
    mem_addr  = 5'd0;
    mem_wdata = '0;
    if (mem_re) begin
      mem_addr = rd;
    end else if (mem_we) begin
      mem_addr = wr;
      if (state == S_EVAL) mem_wdata = row_q;
    end
  end

  // Status and result outputs.
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    lines       = lines_q;
    points_add  = points_q;
    total_lines = total_q;
    level       = level_q;
  end

endmodule

// File: tb/tb_line_clear_ctl.sv
// tb_line_clear_ctl
// Directed bench for line_clear_ctl with a behavioural board RAM. At each
// start the expected pass result is derived from a software compaction of the
// board plus a score/level model and queued; it is popped and compared when
// done pulses.

module tb_line_clear_ctl;

  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam logic [COLS-1:0] FULL = 10'h3FF;

  logic            pclk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [COLS-1:0] mem_rdata = '0;
  logic [4:0]      mem_addr;
  logic            mem_re;
  logic            mem_we;
  logic [COLS-1:0] mem_wdata;
  logic            busy;
  logic            done;
  logic [2:0]      lines;
  logic [19:0]     points_add;
  logic [7:0]      total_lines;
  logic [3:0]      level;

  always #5 pclk = ~pclk;

  line_clear_ctl dut (
    .pclk        (pclk),
    .rst         (rst),
    .start       (start),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .lines       (lines),
    .points_add  (points_add),
    .total_lines (total_lines),
    .level       (level)
  );

  // Board RAM (one cycle read latency) and access bookkeeping.
  logic [COLS-1:0] board      [ROWS];
  logic [COLS-1:0] next_board [ROWS];
  logic            load_req = 1'b0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0, bad_addr_cnt = 0;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (load_req)
      for (int i = 0; i < ROWS; i++) board[i] <= next_board[i];
    if (mem_re) begin
      rd_cnt <= rd_cnt + 1;
      if (int'(mem_addr) < ROWS) mem_rdata <= board[mem_addr];
      else                       bad_addr_cnt <= bad_addr_cnt + 1;
    end
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(mem_addr) < ROWS) board[mem_addr] <= mem_wdata;
      else                       bad_addr_cnt <= bad_addr_cnt + 1;
    end
    if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Scoreboard and reference model state.
  typedef struct {
    int lines;
    int points;
    int total;
    int level;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int m_level = 0, m_sub = 0, m_total = 0;
  int compared = 0, mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int base_of(input int n);
    case (n)
      0:       return 0;
      1:       return 40;
      2:       return 100;
      3:       return 300;
      default: return 1200;
    endcase
  endfunction

  task automatic commit_board();
    @(negedge pclk);
    load_req = 1'b1;
    @(negedge pclk);
    load_req = 1'b0;
  endtask

  task automatic clear_next();
    for (int i = 0; i < ROWS; i++) next_board[i] = '0;
  endtask

  task automatic set_single();
    clear_next();
    next_board[ROWS-1] = FULL;
    commit_board();
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    m_level = 0;
    m_sub   = 0;
    m_total = 0;
  endtask

  // One full pass: model, push, start, wait for done, pop and compare.
  task automatic run_pass(input bit extra_start);
    exp_t e;
    int t0, rd0, wr0, dn0, n, k, bad;
    bit got;
    logic [COLS-1:0] exp_b [ROWS];
    n = 0;
    k = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (board[r] == FULL) n++;
      else begin
        exp_b[k] = board[r];
        k--;
      end
    end
    for (int r = k; r >= 0; r--) exp_b[r] = '0;
    e.lines  = n;
    e.points = base_of(n) * (m_level + 1);
    m_total  = (m_total + n > 255) ? 255 : m_total + n;
    m_sub   += n;
    if (m_sub >= 10) begin
      m_sub -= 10;
      if (m_level < 9) m_level++;
    end
    e.total = m_total;
    e.level = m_level;
    e.lat   = 3 * ROWS + n + 2;
    sb_q.push_back(e);

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    start = 1'b1;
    t0 = cyc;
    @(negedge pclk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (extra_start && i == 10) start = 1'b1;
      @(negedge pclk);
      start = 1'b0;
    end
    e = sb_q.pop_front();
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency",     32'(cyc - t0),        32'(e.lat));
    check("lines",       32'(lines),           32'(e.lines));
    check("points_add",  32'(points_add),      32'(e.points));
    check("total_lines", 32'(total_lines),     32'(e.total));
    check("level",       32'(level),           32'(e.level));
    check("reads",       32'(rd_cnt - rd0),    32'(ROWS));
    check("writes",      32'(wr_cnt - wr0),    32'(ROWS));
    bad = 0;
    for (int r = 0; r < ROWS; r++) if (board[r] !== exp_b[r]) bad++;
    check("board_rows_wrong", 32'(bad), 32'd0);
    @(negedge pclk);
    check("done_width",  32'(done_cnt - dn0),  32'd1);
    check("idle_after",  32'(busy),            32'd0);
    check("points_hold", 32'(points_add),      32'(e.points));
    if (extra_start) begin
      repeat (80) @(negedge pclk);
      check("single_done", 32'(done_cnt - dn0), 32'd1);
      check("no_rescan",   32'(busy),           32'd0);
    end
  endtask

  initial begin
    int t0, rd0, wr0, dn0;

    // Reset state.
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    check("rst_busy",   32'(busy),        32'd0);
    check("rst_done",   32'(done),        32'd0);
    check("rst_re",     32'(mem_re),      32'd0);
    check("rst_we",     32'(mem_we),      32'd0);
    check("rst_addr",   32'(mem_addr),    32'd0);
    check("rst_wdata",  32'(mem_wdata),   32'd0);
    check("rst_lines",  32'(lines),       32'd0);
    check("rst_points", 32'(points_add),  32'd0);
    check("rst_total",  32'(total_lines), 32'd0);
    check("rst_level",  32'(level),       32'd0);

    // Empty board: every row rewritten in place, no FILL.
    clear_next();
    commit_board();
    run_pass(1'b0);

    // Single bottom line with one survivor above it.
    clear_next();
    next_board[21] = FULL;
    next_board[20] = 10'h001;
    commit_board();
    run_pass(1'b0);
    check("t2_points", 32'(points_add), 32'd40);
    check("t2_row21",  32'(board[21]),  32'h001);
    check("t2_row0",   32'(board[0]),   32'h000);

    // Non-adjacent full rows.
    clear_next();
    next_board[21] = FULL;
    next_board[20] = 10'h00F;
    next_board[19] = FULL;
    next_board[18] = 10'h0F0;
    commit_board();
    run_pass(1'b0);
    check("t4_points", 32'(points_add), 32'd100);
    check("t4_row21",  32'(board[21]),  32'h00F);
    check("t4_row20",  32'(board[20]),  32'h0F0);

    // Scattered full rows among random partial rows.
    for (int i = 0; i < ROWS; i++) next_board[i] = 10'($urandom_range(0, 10'h3FE));
    next_board[5]  = FULL;
    next_board[12] = FULL;
    next_board[21] = FULL;
    commit_board();
    run_pass(1'b0);

    // Level progression from reset.
    do_reset();
    for (int p = 0; p < 10; p++) begin
      set_single();
      run_pass(1'b0);
    end
    check("level_at_10", 32'(level), 32'd1);
    for (int p = 0; p < 10; p++) begin
      set_single();
      run_pass(1'b0);
    end
    check("level_at_20", 32'(level), 32'd2);

    // Tetris at level 2.
    clear_next();
    for (int r = 18; r < ROWS; r++) next_board[r] = FULL;
    next_board[17] = 10'h155;
    commit_board();
    run_pass(1'b0);
    check("t3_points", 32'(points_add), 32'd3600);
    check("t3_row21",  32'(board[21]),  32'h155);

    // Climb to 90 lines, then on to 100: level saturates at 9.
    while (m_total < 90) begin
      set_single();
      run_pass(1'b0);
    end
    check("total_at_90", 32'(total_lines), 32'd90);
    check("level_at_90", 32'(level),       32'd9);
    for (int p = 0; p < 10; p++) begin
      set_single();
      run_pass(1'b0);
    end
    check("level_at_100", 32'(level), 32'd9);

    // Tetrises until the cumulative count saturates.
    while (m_total < 255) begin
      clear_next();
      for (int r = 18; r < ROWS; r++) next_board[r] = FULL;
      commit_board();
      run_pass(1'b0);
    end
    check("total_sat", 32'(total_lines), 32'd255);

    // A start pulse while busy is ignored.
    set_single();
    run_pass(1'b1);

    // Reset while in FILL: first FILL cycle is t0+67, writing row 1 with zero.
    clear_next();
    next_board[21] = FULL;
    next_board[20] = FULL;
    commit_board();
    start = 1'b1;
    t0 = cyc;
    @(negedge pclk);
    start = 1'b0;
    while (cyc < t0 + 67) @(negedge pclk);
    check("fill_we",    32'(mem_we),    32'd1);
    check("fill_addr",  32'(mem_addr),  32'd1);
    check("fill_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b1;
    @(negedge pclk);
    check("midrst_busy",  32'(busy),   32'd0);
    check("midrst_we",    32'(mem_we), 32'd0);
    check("midrst_done",  32'(done),   32'd0);
    check("midrst_level", 32'(level),  32'd0);
    rst = 1'b0;
    m_level = 0;
    m_sub   = 0;
    m_total = 0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    repeat (10) @(negedge pclk);
    check("midrst_no_reads",  32'(rd_cnt - rd0),   32'd0);
    check("midrst_no_writes", 32'(wr_cnt - wr0),   32'd0);
    check("midrst_no_done",   32'(done_cnt - dn0), 32'd0);
    check("midrst_total",     32'(total_lines),    32'd0);

    // Global protocol invariants.
    check("re_we_overlap", 32'(both_cnt),     32'd0);
    check("bad_address",   32'(bad_addr_cnt), 32'd0);
    check("sb_empty",      32'(sb_q.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
